// File: rtl/sr_pulse_driver.sv
// Debounced set/reset pushbuttons driving non-overlapping active-low strobes
// into a downstream NAND SR latch, with reset-first arbitration and a guard gap.
module sr_pulse_driver #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 3,
  parameter int GAP_CYCLES      = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_set,
  input  logic btn_reset,
  output logic s_n,
  output logic r_n,
  output logic busy
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] SET_PULSE   = 2'd1;
  localparam logic [1:0] RESET_PULSE = 2'd2;
  localparam logic [1:0] GAP         = 2'd3;

  localparam logic [15:0] DEB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  PULSE_LAST = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0]  GAP_LAST   = 8'(GAP_CYCLES - 1);

  // Channel index 0 is the set button, index 1 is the reset button.
  logic [1:0]  w_btn;
  logic [1:0]  r_sync1;
  logic [1:0]  r_sync2;
  logic [1:0]  r_deb;
  logic [1:0]  r_deb_d;
  logic [1:0]  r_pend;
  logic [15:0] r_dcnt [2];
  logic [1:0]  w_rise;
  logic [1:0]  w_serve;
  logic        w_launch;
  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [7:0]  r_cnt;
  logic        r_s_n;
  logic        r_r_n;

  assign w_btn = {btn_reset, btn_set};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
    end
  end

  // The count tracks how long the synchronised sample has disagreed with the
  // accepted level; any agreeing sample restarts the qualification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb    <= 2'b00;
      r_deb_d  <= 2'b00;
      r_dcnt[0] <= 16'd0;
      r_dcnt[1] <= 16'd0;
    end else begin
      r_deb_d <= r_deb;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] != r_deb[i]) begin
          if (r_dcnt[i] == DEB_LAST) begin
            r_deb[i]  <= ~r_deb[i];
            r_dcnt[i] <= 16'd0;
          end else begin
            r_dcnt[i] <= r_dcnt[i] + 16'd1;
          end
        end else begin
          r_dcnt[i] <= 16'd0;
        end
      end
    end
  end

  assign w_rise = r_deb & ~r_deb_d;

  // The end of a gap arbitrates exactly like IDLE, so a queued request follows
  // after precisely GAP_CYCLES high clocks instead of an extra idle clock.
  always_comb begin
    w_state_nxt = r_state;
    w_serve     = 2'b00;
    w_launch    = (r_state == IDLE) || ((r_state == GAP) && (r_cnt == GAP_LAST));
    if ((r_state == SET_PULSE || r_state == RESET_PULSE) && (r_cnt == PULSE_LAST)) begin
      w_state_nxt = GAP;
    end
    if (w_launch) begin
      if (r_pend[1]) begin
        w_state_nxt = RESET_PULSE;
        w_serve     = 2'b10;
      end else if (r_pend[0]) begin
        w_state_nxt = SET_PULSE;
        w_serve     = 2'b01;
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_s_n   <= 1'b1;
      r_r_n   <= 1'b1;
      r_pend  <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      if ((w_state_nxt != r_state) || (w_state_nxt == IDLE)) begin
        r_cnt <= 8'd0;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
      // Strobes decode from a single next-state value, so both can never be low.
      r_s_n  <= (w_state_nxt != SET_PULSE);
      r_r_n  <= (w_state_nxt != RESET_PULSE);
      r_pend <= w_rise | (r_pend & ~w_serve);
    end
  end

  assign s_n  = r_s_n;
  assign r_n  = r_r_n;
  assign busy = (r_state != IDLE);

endmodule
